mem_ctrl: RTL and testbench

- Memory controller between the CPU core's fetch/load-store units and the byte-wide RAM/IO bus in riscv_top.
- Serialises word instruction fetches and byte/half/word loads and stores into one-byte-per-cycle bus transactions.
- Honours io_buffer_full for writes to the IO region.
- Assembles little-endian read data.

---
 rtl/mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns word fetches and byte/half/word loads/stores
// into one-byte-per-cycle RAM/IO bus transactions with little-endian assembly.
module mem_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter logic [1:0]  IO_MASK = 2'b11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata
);

  typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [2:0]        len, len_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [31:0]       wbuf, wbuf_nxt;
  logic [31:0]       rbuf, rbuf_nxt;
  logic [7:0]        mem_dout_nxt;
  logic [ADDR_W-1:0] mem_a_nxt;
  logic              mem_wr_nxt, if_done_nxt, ls_done_nxt;
  logic [31:0]       if_data_nxt, ls_rdata_nxt;
  logic [2:0]        step;
  logic [1:0]        bidx;
  logic              stall;

  function automatic logic [2:0] size_len(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      base     <= '0;
      wbuf     <= '0;
      rbuf     <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      len      <= len_nxt;
      base     <= base_nxt;
      wbuf     <= wbuf_nxt;
      rbuf     <= rbuf_nxt;
      mem_a    <= mem_a_nxt;
      mem_dout <= mem_dout_nxt;
      mem_wr   <= mem_wr_nxt;
      if_done  <= if_done_nxt;
      ls_done  <= ls_done_nxt;
      if_data  <= if_data_nxt;
      ls_rdata <= ls_rdata_nxt;
    end
  end

  // Reads: cnt = edges since accept minus one (byte k issued at edge k, captured at k+2).
  // Writes: cnt = bytes already issued; an IO stall simply leaves it unchanged.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    len_nxt      = len;
    base_nxt     = base;
    wbuf_nxt     = wbuf;
    rbuf_nxt     = rbuf;
    mem_a_nxt    = mem_a;
    mem_dout_nxt = mem_dout;
    mem_wr_nxt   = 1'b0;
    if_done_nxt  = 1'b0;
    ls_done_nxt  = 1'b0;
    if_data_nxt  = if_data;
    ls_rdata_nxt = ls_rdata;
    step         = cnt + 3'd1;
    bidx         = 2'(step - 3'd2);
    stall        = (base[17:16] == IO_MASK) && io_buffer_full;

    case (state)
      IDLE: begin
        if (!(if_done || ls_done)) begin
          if (ls_req) begin
            base_nxt = ls_addr;
            len_nxt  = size_len(ls_size);
            wbuf_nxt = ls_wdata;
            rbuf_nxt = '0;
            cnt_nxt  = '0;
            if (ls_we) begin
              state_nxt = LS_WRITE;
              if (!((ls_addr[17:16] == IO_MASK) && io_buffer_full)) begin
                mem_a_nxt    = ls_addr;
                mem_dout_nxt = ls_wdata[7:0];
                mem_wr_nxt   = 1'b1;
                cnt_nxt      = 3'd1;
              end
            end else begin
              state_nxt = LS_READ;
              mem_a_nxt = ls_addr;
            end
          end else if (if_req && !if_flush) begin
            state_nxt = IF_READ;
            base_nxt  = if_addr;
            len_nxt   = 3'd4;
            rbuf_nxt  = '0;
            cnt_nxt   = '0;
            mem_a_nxt = if_addr;
          end
        end
      end

      IF_READ, LS_READ: begin
        if (state == IF_READ && if_flush) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = step;
          if (step < len)
            mem_a_nxt = base + ADDR_W'(step);
          if (step >= 3'd2)
            rbuf_nxt[{bidx, 3'b000} +: 8] = mem_din;
          if (step == 3'(len + 3'd1)) begin
            state_nxt = IDLE;
            if (state == IF_READ) begin
              if_done_nxt = 1'b1;
              if_data_nxt = rbuf_nxt;
            end else begin
              ls_done_nxt  = 1'b1;
              ls_rdata_nxt = rbuf_nxt;
            end
          end
        end
      end

      LS_WRITE: begin
        if (cnt == len) begin
          state_nxt   = IDLE;
          ls_done_nxt = 1'b1;
        end else if (!stall) begin
          mem_a_nxt    = base + ADDR_W'(cnt);
          mem_dout_nxt = wbuf[{cnt[1:0], 3'b000} +: 8];
          mem_wr_nxt   = 1'b1;
          cnt_nxt      = cnt + 3'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: table of directed requests against a byte RAM model,
// plus hand sequences for arbitration, IO stall, flush and mid-transaction reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .IO_MASK(2'b11)) dut (
    .clk(clk), .rst_n(rst_n), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  // RAM: registers the address each edge, data appears the following cycle.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[16'h1000] <= 8'h13; ram[16'h1001] <= 8'h05;
      ram[16'h1002] <= 8'h00; ram[16'h1003] <= 8'h00;
      ram[16'h2000] <= 8'h78; ram[16'h2001] <= 8'h56;
      ram[16'h2002] <= 8'hFE; ram[16'h2003] <= 8'hFF;
      ram[16'h3002] <= 8'h11; ram[16'h3003] <= 8'h22;
      ram[16'hFFFE] <= 8'hA1; ram[16'hFFFF] <= 8'hB2;
      ram[16'h0000] <= 8'hC3; ram[16'h0001] <= 8'hD4;
    end else if (mem_wr && mem_a[17:16] != 2'b11) begin
      ram[mem_a[15:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[15:0]];
  end

  typedef struct {
    bit          port;      // 1 = fetch, 0 = load/store
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;   // edges from accept to done
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, output int lat, output logic [31:0] data,
                         output logic done_after);
    @(negedge clk);
    if (v.port) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      ls_req = 1'b1; ls_we = v.we; ls_size = v.size; ls_addr = v.addr; ls_wdata = v.wdata;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(v.port ? if_done : ls_done) && lat < 20);
    data = v.port ? if_data : ls_rdata;
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0;
    @(posedge clk); #1;
    done_after = v.port ? if_done : ls_done;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] data;
    logic        da;
    int          ls_edge, if_edge;
    logic        seen;
    vec_t        v;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         32'h0000_0513, 5};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'hFFFE_5678, 5};
    vecs[2]  = '{1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'hFFFE_5678, 5};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_2002, 32'h0,         32'h0000_FFFE, 3};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_2001, 32'h0,         32'h0000_0056, 2};
    vecs[5]  = '{1'b0, 1'b0, 2'd0, 32'h0000_2003, 32'h0,         32'h0000_00FF, 2};
    vecs[6]  = '{1'b0, 1'b0, 2'd3, 32'h0000_2000, 32'h0,         32'hFFFE_5678, 5};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 32'h0000_3000, 32'h9999_ABCD, 32'h0,         2};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_3000, 32'h0,         32'h2211_ABCD, 5};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 32'h0000_4000, 32'hCAFE_BABE, 32'h0,         4};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h0000_4000, 32'h0,         32'hCAFE_BABE, 5};
    vecs[11] = '{1'b0, 1'b1, 2'd0, 32'h0000_4001, 32'h1234_5677, 32'h0,         1};
    vecs[12] = '{1'b0, 1'b0, 2'd2, 32'h0000_4000, 32'h0,         32'hCAFE_77BE, 5};
    vecs[13] = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hD4C3_B2A1, 5};

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    check("rst_if_done", {31'h0, if_done}, 32'h0);
    check("rst_ls_done", {31'h0, ls_done}, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i], lat, data, da);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].we) check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("v%0d_one_cycle_done", i), {31'h0, da}, 32'h0);
    end

    // Fetch address stepping
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("fetch_mem_a_%0d", k), mem_a, 32'h1000 + k);
      check($sformatf("fetch_mem_wr_%0d", k), {31'h0, mem_wr}, 32'h0);
    end
    @(posedge clk); #1;
    check("fetch_done_early", {31'h0, if_done}, 32'h0);
    @(posedge clk); #1;
    check("fetch_done_e5", {31'h0, if_done}, 32'h1);
    check("fetch_data", if_data, 32'h0000_0513);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);

    // Simultaneous requests: load first, fetch accepted one cycle after ls_done
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h1000;
    if_req = 1'b1; if_addr = 32'h2000;
    @(posedge clk);
    ls_edge = 0; if_edge = 0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      if (ls_done && ls_edge == 0) ls_edge = e;
      if (if_done && if_edge == 0) if_edge = e;
      @(negedge clk);
      if (ls_done) ls_req = 1'b0;
      if (if_done) if_req = 1'b0;
    end
    ls_req = 1'b0; if_req = 1'b0;
    check("arb_ls_done_edge", ls_edge, 32'd5);
    check("arb_if_done_edge", if_edge, 32'd12);
    check("arb_ls_rdata", ls_rdata, 32'h0000_0513);
    check("arb_if_data", if_data, 32'hFFFE_5678);

    // IO store stalled by io_buffer_full for three cycles
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h41;
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("io_stall_wr_%0d", k), {31'h0, mem_wr}, 32'h0);
      check($sformatf("io_stall_done_%0d", k), {31'h0, ls_done}, 32'h0);
    end
    @(negedge clk);
    io_buffer_full = 1'b0;
    @(posedge clk); #1;
    check("io_write_wr", {31'h0, mem_wr}, 32'h1);
    check("io_write_a", mem_a, 32'h0003_0000);
    check("io_write_dout", {24'h0, mem_dout}, 32'h41);
    check("io_write_done_early", {31'h0, ls_done}, 32'h0);
    @(posedge clk); #1;
    check("io_done", {31'h0, ls_done}, 32'h1);
    check("io_done_wr", {31'h0, mem_wr}, 32'h0);
    @(negedge clk);
    ls_req = 1'b0;
    @(negedge clk);

    // Flush during fetch, then flushed request in IDLE is ignored
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if_flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if_addr = 32'h5000;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (if_done) seen = 1'b1;
    end
    check("flush_idle_not_accepted", mem_a, 32'h1001);
    @(negedge clk);
    if_req = 1'b0; if_flush = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (if_done) seen = 1'b1;
    end
    check("flush_no_done", {31'h0, seen}, 32'h0);
    v = '{1'b1, 1'b0, 2'd2, 32'h1000, 32'h0, 32'h0000_0513, 5};
    run_req(v, lat, data, da);
    check("post_flush_latency", lat, 32'd5);
    check("post_flush_data", data, 32'h0000_0513);

    // Reset in the middle of a word store
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("st_b0_dout", {24'h0, mem_dout}, 32'hEF);
    check("st_b0_wr", {31'h0, mem_wr}, 32'h1);
    @(posedge clk); #1;
    check("st_b1_dout", {24'h0, mem_dout}, 32'hBE);
    check("st_b1_a", mem_a, 32'h101);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_a", mem_a, 32'h0);
    check("mid_rst_dout", {24'h0, mem_dout}, 32'h0);
    check("mid_rst_wr", {31'h0, mem_wr}, 32'h0);
    check("mid_rst_if_data", if_data, 32'h0);
    check("mid_rst_ls_rdata", ls_rdata, 32'h0);
    @(negedge clk);
    ls_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ls_done) seen = 1'b1;
    end
    check("mid_rst_no_done", {31'h0, seen}, 32'h0);
    v = '{1'b0, 1'b0, 2'd0, 32'h2001, 32'h0, 32'h0000_0056, 2};
    run_req(v, lat, data, da);
    check("post_rst_latency", lat, 32'd2);
    check("post_rst_data", data, 32'h0000_0056);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
